voxel_ram_arbiter: RTL and testbench

Round-robin arbiter that shares one read port of the voxel block RAM among `NUM_PORTS` voxel traversal units, so that several rays can be in flight at once. It accepts level-held read requests, which is the native VTU memory handshake. It issues at most one RAM read per cycle and tracks each read through a tag pipeline matched to the fixed RAM latency. It routes each result back to the requester that issued it as a one-cycle valid pulse. It sits between the VTU array and the world/chunk block RAM.

---
 rtl/voxel_ram_arbiter.sv | 126 ++++++++++++
 tb/tb_voxel_ram_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voxel_ram_arbiter.sv
// Round-robin arbiter sharing one voxel block-RAM read port among NUM_PORTS traversal units.
// Each issued read carries a port tag through a pipeline matched to the fixed RAM latency.

package voxel_pkg;
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
    } BlockPos;

    typedef logic [7:0] BlockType;

    localparam BlockType BLOCK_AIR   = 8'd0;
    localparam BlockType BLOCK_STONE = 8'd1;
endpackage

module voxel_ram_arbiter
    import voxel_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int RAM_LATENCY = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  BlockPos  [NUM_PORTS-1:0] req_addr,
    input  logic     [NUM_PORTS-1:0] req_en,
    output BlockType [NUM_PORTS-1:0] resp_data,
    output logic     [NUM_PORTS-1:0] resp_valid,
    output BlockPos                  mem_addr,
    output logic                     mem_read_enable,
    input  BlockType                 mem_out,
    output logic                     busy
);
    localparam int IDX_W = $clog2(NUM_PORTS);
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(NUM_PORTS - 1);

    logic [1:0]             rst_sync;
    logic                   rst_n;
    logic [NUM_PORTS-1:0]   pending;
    logic [NUM_PORTS-1:0]   pending_next;
    logic [NUM_PORTS-1:0]   eligible;
    logic [NUM_PORTS-1:0]   grant_vec;
    logic                   grant_valid;
    idx_t                   grant_idx;
    idx_t                   rr_ptr;
    idx_t                   issue_idx;
    logic [RAM_LATENCY-1:0] tag_valid;
    idx_t [RAM_LATENCY-1:0] tag_idx;
    int                     cand;

    // Assertion reaches every flop at once; release is re-timed to clk_in.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        eligible    = req_en & ~pending & ~resp_valid;
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        grant_vec   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_PORTS;
            if (!grant_valid && eligible[idx_t'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_t'(cand);
            end
        end
        if (grant_valid) begin
            grant_vec[grant_idx] = 1'b1;
        end
        pending_next = (pending & ~resp_valid) | grant_vec;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr          <= LAST_IDX;
            pending         <= '0;
            busy            <= 1'b0;
            mem_addr        <= '0;
            mem_read_enable <= 1'b0;
            tag_valid       <= '0;
            resp_valid      <= '0;
            resp_data       <= {NUM_PORTS{BLOCK_AIR}};
        end else begin
            pending         <= pending_next;
            busy            <= |pending_next;
            mem_read_enable <= grant_valid;
            if (grant_valid) begin
                rr_ptr   <= grant_idx;
                mem_addr <= req_addr[grant_idx];
            end

            // Stage 0 follows the issue register, so the tail lines up with mem_out.
            tag_valid[0] <= mem_read_enable;
            for (int s = 1; s < RAM_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
            end

            resp_valid <= '0;
            if (tag_valid[RAM_LATENCY-1]) begin
                resp_valid[tag_idx[RAM_LATENCY-1]] <= 1'b1;
                resp_data[tag_idx[RAM_LATENCY-1]]  <= mem_out;
            end
        end
    end

    // NOTE: the index pipeline is left unreset; its contents only matter when the matching valid is set.
    always_ff @(posedge clk_in) begin
        issue_idx  <= grant_idx;
        tag_idx[0] <= issue_idx;
        for (int s = 1; s < RAM_LATENCY; s++) begin
            tag_idx[s] <= tag_idx[s-1];
        end
    end

endmodule

// File: tb/tb_voxel_ram_arbiter.sv
// Self-checking bench for voxel_ram_arbiter: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations and a randomized phase.

module tb_voxel_ram_arbiter;
    import voxel_pkg::*;

    localparam int NP  = 4;
    localparam int LAT = 2;

    logic              clk_in   = 1'b0;
    logic              rst_in   = 1'b0;
    BlockPos  [NP-1:0] req_addr = '0;
    logic     [NP-1:0] req_en   = '0;
    BlockType [NP-1:0] resp_data;
    logic     [NP-1:0] resp_valid;
    BlockPos           mem_addr;
    logic              mem_read_enable;
    BlockType          mem_out;
    logic              busy;

    int n_checks = 0;
    int n_err    = 0;
    logic cmp_en = 1'b0;

    voxel_ram_arbiter #(.NUM_PORTS(NP), .RAM_LATENCY(LAT)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .req_addr        (req_addr),
        .req_en          (req_en),
        .resp_data       (resp_data),
        .resp_valid      (resp_valid),
        .mem_addr        (mem_addr),
        .mem_read_enable (mem_read_enable),
        .mem_out         (mem_out),
        .busy            (busy)
    );

    always #5 clk_in = ~clk_in;

    function automatic BlockType ram_f(input BlockPos a);
        logic [7:0] h;
        if (a.x == 8'd3 && a.y == 8'd5 && a.z == 8'd7) return BLOCK_STONE;
        h = a.x * 8'd7 + a.y * 8'd13 + a.z * 8'd29 + 8'd17;
        return h;
    endfunction

    function automatic BlockPos pos(input int x, input int y, input int z);
        BlockPos a;
        a.x = 8'(x);
        a.y = 8'(y);
        a.z = 8'(z);
        return a;
    endfunction

    // Block RAM: data for a presented address appears LAT cycles later; junk otherwise.
    BlockType ram_pipe [LAT];
    always @(posedge clk_in) begin
        ram_pipe[0] <= mem_read_enable ? ram_f(mem_addr) : 8'($urandom);
        for (int k = 1; k < LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
    end
    assign mem_out = ram_pipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of in-flight reads, each with the edge at which its response lands.
    typedef struct {
        int      due;
        int      port;
        BlockPos addr;
    } flight_t;

    flight_t       flights[$];
    int            m_edge    = 0;
    int            m_rel     = 0;
    int            m_rr      = NP - 1;
    logic [NP-1:0] m_pending = '0;
    logic [NP-1:0] m_rv      = '0;
    logic          m_re      = 1'b0;
    logic          m_busy    = 1'b0;
    BlockPos       m_addr    = '0;
    BlockType      m_rd [NP] = '{default: 8'd0};

    task automatic model_reset();
        flights.delete();
        m_rel     = 0;
        m_rr      = NP - 1;
        m_pending = '0;
        m_rv      = '0;
        m_re      = 1'b0;
        m_busy    = 1'b0;
        m_addr    = '0;
        for (int p = 0; p < NP; p++) m_rd[p] = BLOCK_AIR;
    endtask

    task automatic model_step();
        int            g;
        int            c;
        logic [NP-1:0] elig;
        logic [NP-1:0] rv_next;
        flight_t       f;
        m_edge++;
        elig = req_en & ~m_pending & ~m_rv;
        g = -1;
        for (int k = 1; k <= NP; k++) begin
            c = (m_rr + k) % NP;
            if (g < 0 && elig[c]) g = c;
        end
        rv_next = '0;
        if (flights.size() > 0 && flights[0].due == m_edge) begin
            rv_next[flights[0].port] = 1'b1;
            m_rd[flights[0].port]    = ram_f(flights[0].addr);
            void'(flights.pop_front());
        end
        m_pending = m_pending & ~m_rv;
        m_re      = (g >= 0);
        if (g >= 0) begin
            m_pending[g] = 1'b1;
            m_rr         = g;
            m_addr       = req_addr[g];
            f.due        = m_edge + LAT + 1;
            f.port       = g;
            f.addr       = req_addr[g];
            flights.push_back(f);
        end
        m_rv   = rv_next;
        m_busy = |m_pending;
    endtask

    // Internal reset release takes two edges with rst_in high.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) model_reset();
        else if (m_rel < 2) m_rel++;
        else model_step();
    end

    always @(negedge clk_in) begin
        if (cmp_en) begin
            check("mem_read_enable", 32'(mem_read_enable), 32'(m_re));
            check("mem_addr", {8'd0, mem_addr}, {8'd0, m_addr});
            check("resp_valid", 32'(resp_valid), 32'(m_rv));
            check("busy", 32'(busy), 32'(m_busy));
            for (int p = 0; p < NP; p++)
                check($sformatf("resp_data[%0d]", p), 32'(resp_data[p]), 32'(m_rd[p]));
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        ticks(2);
    endtask

    initial begin
        int grants [NP];
        int outst  [NP];
        int seqn   [NP];
        logic [NP-1:0] seen;
        int reads, max_out, hi, lo, wreads;

        ticks(3);
        cmp_en = 1'b1;
        check("rst_mem_re", 32'(mem_read_enable), 32'd0);
        check("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        rst_in = 1'b1;
        ticks(2);

        // Single port, fixed address returning stone.
        req_addr[0] = pos(3, 5, 7);
        req_en      = 4'b0001;
        tick();
        check("single_issue_re", 32'(mem_read_enable), 32'd1);
        check("single_issue_addr", {8'd0, mem_addr}, 32'h030507);
        tick();
        check("single_no_reissue", 32'(mem_read_enable), 32'd0);
        tick();
        check("single_rv_early", 32'(resp_valid), 32'd0);
        tick();
        check("single_rv", 32'(resp_valid), 32'b0001);
        check("single_data", 32'(resp_data[0]), 32'(BLOCK_STONE));
        check("single_busy", 32'(busy), 32'd1);
        req_en = '0;
        tick();
        check("single_rv_pulse", 32'(resp_valid), 32'd0);
        check("single_idle", 32'(busy), 32'd0);

        // Fairness: ports 0 and 2 together straight after reset.
        do_reset();
        req_addr[0] = pos(10, 0, 1);
        req_addr[2] = pos(12, 2, 3);
        req_en      = 4'b0101;
        tick();
        check("fair_first_re", 32'(mem_read_enable), 32'd1);
        check("fair_first_addr", {8'd0, mem_addr}, 32'h0a0001);
        tick();
        check("fair_second_re", 32'(mem_read_enable), 32'd1);
        check("fair_second_addr", {8'd0, mem_addr}, 32'h0c0203);
        req_en = '0;
        tick();
        check("fair_gap_re", 32'(mem_read_enable), 32'd0);
        tick();
        check("fair_rv0", 32'(resp_valid), 32'b0001);
        check("fair_data0", 32'(resp_data[0]), 32'(ram_f(pos(10, 0, 1))));
        tick();
        check("fair_rv2", 32'(resp_valid), 32'b0100);
        check("fair_data2", 32'(resp_data[2]), 32'(ram_f(pos(12, 2, 3))));
        ticks(3);

        // Saturation: four VTUs, each moving to a new address after its response.
        for (int p = 0; p < NP; p++) begin
            seqn[p]     = 0;
            grants[p]   = 0;
            outst[p]    = 0;
            req_addr[p] = pos(p, 0, $urandom_range(0, 255));
        end
        seen    = '0;
        reads   = 0;
        max_out = 0;
        req_en  = '1;
        for (int c = 0; c < 100; c++) begin
            tick();
            for (int p = 0; p < NP; p++) begin
                if (seen[p]) begin
                    seqn[p]++;
                    req_addr[p] = pos(p, seqn[p], $urandom_range(0, 255));
                end
                if (resp_valid[p]) begin
                    check("sat_resp_data", 32'(resp_data[p]), 32'(ram_f(req_addr[p])));
                    outst[p]--;
                end
            end
            if (mem_read_enable) begin
                reads++;
                if (int'(mem_addr.x) < NP) begin
                    grants[mem_addr.x]++;
                    outst[mem_addr.x]++;
                end
            end
            for (int p = 0; p < NP; p++) if (outst[p] > max_out) max_out = outst[p];
            seen = resp_valid;
        end
        hi = grants[0];
        lo = grants[0];
        for (int p = 1; p < NP; p++) begin
            if (grants[p] > hi) hi = grants[p];
            if (grants[p] < lo) lo = grants[p];
        end
        check("sat_reads", 32'(reads), 32'd80);
        check("sat_balance", 32'(hi - lo <= 1), 32'd1);
        check("sat_max_outstanding", 32'(max_out), 32'd1);
        req_en = '0;
        ticks(8);

        // Holdoff: port 1 moves its address on the edge after its valid pulse.
        req_addr[1] = pos(1, 100, 1);
        req_en      = 4'b0010;
        tick();
        check("hold_issue_re", 32'(mem_read_enable), 32'd1);
        check("hold_issue_addr", {8'd0, mem_addr}, 32'h016401);
        ticks(2);
        check("hold_wait_re", 32'(mem_read_enable), 32'd0);
        tick();
        check("hold_rv", 32'(resp_valid), 32'b0010);
        check("hold_data", 32'(resp_data[1]), 32'(ram_f(pos(1, 100, 1))));
        tick();
        req_addr[1] = pos(1, 101, 2);
        check("hold_no_stale", 32'(mem_read_enable), 32'd0);
        tick();
        check("hold_new_re", 32'(mem_read_enable), 32'd1);
        check("hold_new_addr", {8'd0, mem_addr}, 32'h016502);
        req_en = '0;
        ticks(6);

        // Withdrawal: port 3 drops its request right after being granted.
        req_addr[3] = pos(3, 33, 3);
        req_en      = 4'b1000;
        tick();
        check("wd_issue_addr", {8'd0, mem_addr}, 32'h032103);
        req_en = '0;
        wreads = 0;
        ticks(2);
        wreads += int'(mem_read_enable);
        tick();
        wreads += int'(mem_read_enable);
        check("wd_rv", 32'(resp_valid), 32'b1000);
        check("wd_busy_during", 32'(busy), 32'd1);
        tick();
        wreads += int'(mem_read_enable);
        check("wd_rv_after", 32'(resp_valid), 32'd0);
        check("wd_busy_after", 32'(busy), 32'd0);
        tick();
        wreads += int'(mem_read_enable);
        check("wd_no_reissue", 32'(wreads), 32'd0);

        // Asynchronous reset between edges with two reads in flight.
        req_addr[0] = pos(0, 7, 7);
        req_addr[1] = pos(1, 7, 7);
        req_en      = 4'b0011;
        ticks(2);
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_re", 32'(mem_read_enable), 32'd0);
        check("arst_addr", {8'd0, mem_addr}, 32'd0);
        check("arst_rv", 32'(resp_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_data", 32'(resp_data), 32'd0);
        tick();
        rst_in = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("arst_no_stale_rv", 32'(resp_valid), 32'd0);
            check("arst_held_re", 32'(mem_read_enable), 32'd0);
        end
        tick();
        check("arst_first_re", 32'(mem_read_enable), 32'd1);
        check("arst_first_port0", {8'd0, mem_addr}, 32'h000707);
        tick();
        check("arst_second_port1", {8'd0, mem_addr}, 32'h010707);
        req_en = '0;
        ticks(8);

        // Randomized traffic, withdrawals and occasional resets, checked against the model.
        for (int c = 0; c < 800; c++) begin
            tick();
            if (!rst_in) rst_in = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_in = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 3) == 0) req_en[p] = ~req_en[p];
                if ($urandom_range(0, 2) == 0)
                    req_addr[p] = pos($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            end
        end
        req_en = '0;
        rst_in = 1'b1;
        ticks(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
